// File: rtl/core_ctrl_pkg.sv
// Shared control-path types for the in-order core: hazard sequencer states and
// register-file constants.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MUL_WAIT  = 2'd1,
        EXC_WAIT  = 2'd2,
        EXC_FLUSH = 2'd3
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the
// instruction in ID.
module hazard_detect
    import core_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
        // x0 is hardwired, so a load targeting it never produces a dependency
        load_use = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: drives PC write-enable and the
// hold/flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
module pipeline_hazard_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_mispredict,
    input  logic       ex_mul_start,
    input  logic       i_cache_stall,
    input  logic       d_cache_stall,
    input  logic       rob_full,
    input  logic       exc_valid,
    output logic       pc_write,
    output logic       pc_sel_exc,
    output logic       exc_ack,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_stall,
    output logic       idex_flush,
    output logic       exmem_stall,
    output logic       exmem_flush
);

    localparam logic [CNT_W-1:0] MUL_HOLD = CNT_W'(MUL_LAT - 1);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        pc_write    = 1'b1;
        pc_sel_exc  = 1'b0;
        exc_ack     = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;

        unique case (state_q)
            RUN: begin
                if (exc_valid && d_cache_stall) begin
                    state_d     = EXC_WAIT;
                    pc_write    = 1'b0;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                end else if (exc_valid) begin
                    state_d = EXC_FLUSH;
                end else if (d_cache_stall) begin
                    // A pending mispredict stays in EX and is acted on once the miss clears
                    pc_write    = 1'b0;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                end else if (ex_mispredict) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_mul_start) begin
                    state_d     = MUL_WAIT;
                    mul_cnt_d   = MUL_HOLD;
                    pc_write    = 1'b0;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use || rob_full) begin
                    pc_write   = 1'b0;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end else if (i_cache_stall) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                end
            end

            MUL_WAIT: begin
                pc_write   = 1'b0;
                ifid_stall = 1'b1;
                idex_stall = 1'b1;
                if (d_cache_stall) begin
                    exmem_stall = 1'b1;
                end else begin
                    exmem_flush = 1'b1;
                end
                if (exc_valid) begin
                    state_d = d_cache_stall ? EXC_WAIT : EXC_FLUSH;
                end else if (!d_cache_stall) begin
                    mul_cnt_d = mul_cnt_q - 1'b1;
                    if (mul_cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end

            EXC_WAIT: begin
                pc_write    = 1'b0;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                if (!d_cache_stall) begin
                    state_d = EXC_FLUSH;
                end
            end

            EXC_FLUSH: begin
                pc_sel_exc  = 1'b1;
                exc_ack     = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                state_d     = RUN;
            end

            default: state_d = RUN;
        endcase

        if (reset) begin
            pc_write    = 1'b0;
            pc_sel_exc  = 1'b0;
            exc_ack     = 1'b0;
            ifid_stall  = 1'b0;
            idex_stall  = 1'b0;
            exmem_stall = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end
    end

endmodule
